ff_hit_serializer: RTL and testbench

FF_HIT_SERIALIZER -- requirements
Module: ff_hit_serializer

---
 rtl/ff_hit_serializer.sv | 182 ++++++++++++++++++
 tb/tb_ff_hit_serializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_hit_serializer.sv
// ff_hit_serializer: buffers first-filter words that contain bucket hits and emits one
// (offset, mask) record per hit lane. Define FF_HIT_SERIALIZER_STATS_EN to enable drop_cnt.
module ff_hit_serializer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OFF_WIDTH  = 16,
    localparam int unsigned FP_DWIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FP_DWIDTH-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 in_eop,
    output logic [OFF_WIDTH-1:0] out_offset,
    output logic [7:0]           out_mask,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic [15:0]          drop_cnt
);
    localparam int unsigned LANES = FP_DWIDTH / 8;
    localparam int unsigned IW    = $clog2(LANES);
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;

    function automatic logic [IW-1:0] lowest_idx(input logic [LANES-1:0] v);
        lowest_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IW'(i);
        end
    endfunction

    // Stage 1: word base offset and per-lane hit detection
    logic [OFF_WIDTH-1:0] next_base;
    logic [OFF_WIDTH-1:0] word_base;
    logic [LANES-1:0]     lane_hit;
    logic                 s1_valid;
    logic [FP_DWIDTH-1:0] s1_data;
    logic [OFF_WIDTH-1:0] s1_base;
    logic                 s1_eop;
    logic [LANES-1:0]     s1_hit;

    always_comb begin
        word_base = in_sop ? '0 : next_base;
        lane_hit  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_hit[i] = ~&in_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            next_base <= '0;
            s1_data   <= '0;
            s1_base   <= '0;
            s1_eop    <= 1'b0;
            s1_hit    <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                next_base <= word_base + OFF_WIDTH'(16);
                s1_data   <= in_data;
                s1_base   <= word_base;
                s1_eop    <= in_eop;
                s1_hit    <= lane_hit;
            end
        end
    end

    // Hit-word FIFO; the entry being serialized stays at the head until its last hit leaves
    logic [FP_DWIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [OFF_WIDTH-1:0] mem_base [FIFO_DEPTH];
    logic                 mem_eop  [FIFO_DEPTH];
    logic [LANES-1:0]     mem_hit  [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr, rd_ptr_n;
    logic [CW-1:0]        count, count_n, cnt_after_pop;
    logic [LANES-1:0]     rem, rem_low, rem_n, rem_n_low;

    logic push, consume, pop, full, accept, drop, bypass;
    logic [FP_DWIDTH-1:0] head_data_n;
    logic [OFF_WIDTH-1:0] head_base_n;
    logic                 head_eop_n;
    logic [LANES-1:0]     head_hit_n;
    logic [IW-1:0]        idx_n;
    logic                 valid_n, last_n;
    logic [OFF_WIDTH-1:0] offset_n;
    logic [7:0]           mask_n;

    // Next-state of the FIFO and the output record it will present
    always_comb begin
        push          = s1_valid && (s1_hit != '0);
        consume       = out_valid && out_ready;
        rem_low       = rem & (rem - LANES'(1));
        pop           = consume && (rem_low == '0);
        full          = (count == CW'(FIFO_DEPTH));
        accept        = push && (!full || pop);
        drop          = push && full && !pop;
        cnt_after_pop = count - CW'(pop);
        count_n       = cnt_after_pop + CW'(accept);
        rd_ptr_n      = rd_ptr + PW'(pop);
        bypass        = accept && (cnt_after_pop == '0);

        head_data_n = mem_data[rd_ptr_n];
        head_base_n = mem_base[rd_ptr_n];
        head_eop_n  = mem_eop[rd_ptr_n];
        head_hit_n  = mem_hit[rd_ptr_n];
        if (bypass) begin
            head_data_n = s1_data;
            head_base_n = s1_base;
            head_eop_n  = s1_eop;
            head_hit_n  = s1_hit;
        end

        rem_n = rem;
        if ((count == '0) || pop) begin
            rem_n = (count_n != '0) ? head_hit_n : '0;
        end else if (consume) begin
            rem_n = rem_low;
        end
        rem_n_low = rem_n & (rem_n - LANES'(1));
        idx_n     = lowest_idx(rem_n);

        valid_n  = (count_n != '0);
        offset_n = '0;
        mask_n   = '0;
        last_n   = 1'b0;
        if (valid_n) begin
            offset_n = head_base_n + OFF_WIDTH'(idx_n);
            mask_n   = ~head_data_n[{idx_n, 3'b000} +: 8];
            last_n   = head_eop_n && (rem_n_low == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_ptr] <= s1_data;
            mem_base[wr_ptr] <= s1_base;
            mem_eop[wr_ptr]  <= s1_eop;
            mem_hit[wr_ptr]  <= s1_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rem        <= '0;
            out_valid  <= 1'b0;
            out_offset <= '0;
            out_mask   <= '0;
            out_last   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr_n;
            wr_ptr     <= wr_ptr + PW'(accept);
            count      <= count_n;
            rem        <= rem_n;
            out_valid  <= valid_n;
            out_offset <= offset_n;
            out_mask   <= mask_n;
            out_last   <= last_n;
            overflow   <= overflow | drop;
        end
    end

`ifdef FF_HIT_SERIALIZER_STATS_EN
    // Saturating count of hit words lost to a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ff_hit_serializer.sv
// Bench for ff_hit_serializer: queue-based hit model checked every cycle plus directed literals.
`timescale 1ns/1ps
module tb_ff_hit_serializer;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [15:0] off;
        logic [7:0]  mask;
        logic        last;
    } hit_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic         in_valid, in_sop, in_eop;
    logic [15:0]  out_offset;
    logic [7:0]   out_mask;
    logic         out_last, out_valid, out_ready, overflow;
    logic [15:0]  drop_cnt;

    ff_hit_serializer #(.FIFO_DEPTH(DEPTH), .OFF_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop), .out_offset(out_offset), .out_mask(out_mask),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: expected hits in emission order, hit count per buffered word
    hit_t         hit_q[$];
    int           ent_q[$];
    hit_t         dut_log[$];
    logic         m_s1_v;
    logic [127:0] m_s1_d;
    logic [15:0]  m_s1_b, m_base;
    logic         m_s1_e, m_ovf;
    int           m_drops;
    bit           started = 0;
    bit           fresh   = 0;
    int           last_i, n_hits;
    hit_t         h;
    logic [7:0]   lv;

    always @(posedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready) begin
            h.off = out_offset; h.mask = out_mask; h.last = out_last;
            dut_log.push_back(h);
        end
        if (rst) begin
            hit_q.delete(); ent_q.delete();
            m_s1_v = 0; m_base = 0; m_ovf = 0; m_drops = 0;
            started = 1; fresh = 1;
        end else if (started) begin
            if (hit_q.size() > 0 && out_ready) begin
                void'(hit_q.pop_front());
                ent_q[0] = ent_q[0] - 1;
                if (ent_q[0] == 0) void'(ent_q.pop_front());
            end
            if (m_s1_v) begin
                last_i = -1;
                for (int i = 0; i < 16; i++) if (m_s1_d[8*i +: 8] != 8'hFF) last_i = i;
                if (last_i >= 0) begin
                    if (ent_q.size() < DEPTH) begin
                        n_hits = 0;
                        for (int i = 0; i < 16; i++) begin
                            lv = m_s1_d[8*i +: 8];
                            if (lv != 8'hFF) begin
                                h.off  = m_s1_b + 16'(i);
                                h.mask = ~lv;
                                h.last = m_s1_e && (i == last_i);
                                hit_q.push_back(h);
                                n_hits++;
                            end
                        end
                        ent_q.push_back(n_hits);
                    end else begin
                        m_ovf = 1;
                        if (m_drops < 65535) m_drops++;
                    end
                end
            end
            m_s1_v = in_valid;
            if (in_valid) begin
                m_s1_b = in_sop ? 16'd0 : m_base;
                m_base = m_s1_b + 16'd16;
                m_s1_d = in_data;
                m_s1_e = in_eop;
            end
            if (hit_q.size() > 0) fresh = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic cycle_check();
        logic [15:0] exp_drop;
`ifdef FF_HIT_SERIALIZER_STATS_EN
        exp_drop = 16'(m_drops);
`else
        exp_drop = 16'd0;
`endif
        check("out_valid", 32'(out_valid), 32'(hit_q.size() > 0));
        if (hit_q.size() > 0) begin
            check("out_offset", 32'(out_offset), 32'(hit_q[0].off));
            check("out_mask", 32'(out_mask), 32'(hit_q[0].mask));
            check("out_last", 32'(out_last), 32'(hit_q[0].last));
        end else if (fresh) begin
            check("idle_zero", {15'd0, out_last, out_mask, out_offset}, 32'd0);
        end
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    endtask

    task automatic tick();
        @(negedge clk);
        if (started && !rst) cycle_check();
    endtask

    task automatic word(input logic [127:0] d, input logic s, input logic e);
        in_data = d; in_valid = 1'b1; in_sop = s; in_eop = e;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '1;
    endtask

    task automatic wait_log(input int n);
        int t = 0;
        while (dut_log.size() < n && t < 200) begin tick(); t++; end
        check("log_len", 32'(dut_log.size()), 32'(n));
    endtask

    function automatic logic [127:0] set_lane(input logic [127:0] d, input int i, input logic [7:0] v);
        logic [127:0] r;
        r = d;
        r[8*i +: 8] = v;
        return r;
    endfunction

    task automatic check_log(input string name, input int k, input logic [15:0] off,
                             input logic [7:0] mask, input logic last);
        if (k < dut_log.size()) begin
            check({name, "_off"}, 32'(dut_log[k].off), 32'(off));
            check({name, "_mask"}, 32'(dut_log[k].mask), 32'(mask));
            check({name, "_last"}, 32'(dut_log[k].last), 32'(last));
        end else begin
            check({name, "_present"}, 32'(dut_log.size()), 32'(k + 1));
        end
    endtask

    logic [127:0] all_ff;
    int           lb;

    initial begin
        all_ff = '1;
        idle();
        out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_outs", {15'd0, out_last, out_mask, out_offset}, 32'd0);
        tick();

        // Single sop+eop word, lane 3 = 0xFE: two-cycle latency, one record
        out_ready = 1'b1;
        lb = dut_log.size();
        word(set_lane(all_ff, 3, 8'hFE), 1'b1, 1'b1);
        idle();
        check("lat_n1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_n2_valid", 32'(out_valid), 32'd1);
        check("lat_n2_off", 32'(out_offset), 32'd3);
        check("lat_n2_mask", 32'(out_mask), 32'h01);
        check("lat_n2_last", 32'(out_last), 32'd1);
        tick();
        check("t1_drained", 32'(out_valid), 32'd0);
        check("t1_count", 32'(dut_log.size() - lb), 32'd1);

        // Three-word packet: hits on word1 lane0, word2 lanes 5 and 15 (eop)
        lb = dut_log.size();
        word(all_ff, 1'b1, 1'b0);
        word(set_lane(all_ff, 0, 8'h7F), 1'b0, 1'b0);
        word(set_lane(set_lane(all_ff, 5, 8'h00), 15, 8'h55), 1'b0, 1'b1);
        idle();
        wait_log(lb + 3);
        check_log("pkt0", lb + 0, 16'd16, 8'h80, 1'b0);
        check_log("pkt1", lb + 1, 16'd37, 8'hFF, 1'b0);
        check_log("pkt2", lb + 2, 16'd47, 8'hAA, 1'b1);

        // Stall for 10 cycles with lanes 3 and 9 pending
        out_ready = 1'b0;
        lb = dut_log.size();
        word(set_lane(set_lane(all_ff, 3, 8'hFE), 9, 8'h0F), 1'b1, 1'b1);
        idle();
        repeat (11) tick();
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_off", 32'(out_offset), 32'd3);
        check("stall_mask", 32'(out_mask), 32'h01);
        check("stall_last", 32'(out_last), 32'd0);
        out_ready = 1'b1;
        wait_log(lb + 2);
        check_log("rel0", lb + 0, 16'd3, 8'h01, 1'b0);
        check_log("rel1", lb + 1, 16'd9, 8'hF0, 1'b1);

        // Six hit words with ready low: four buffered, two dropped
        out_ready = 1'b0;
        lb = dut_log.size();
        for (int k = 0; k < 6; k++) word(set_lane(all_ff, 0, 8'h00), k == 0, 1'b0);
        idle();
        repeat (2) tick();
        check("ovf_set", 32'(overflow), 32'd1);
`ifdef FF_HIT_SERIALIZER_STATS_EN
        check("drop_two", 32'(drop_cnt), 32'd2);
`else
        check("drop_zero", 32'(drop_cnt), 32'd0);
`endif
        out_ready = 1'b1;
        wait_log(lb + 4);
        for (int k = 0; k < 4; k++) check_log("buf", lb + k, 16'(16 * k), 8'hFF, 1'b0);
        repeat (3) tick();
        check("buf_no_extra", 32'(dut_log.size() - lb), 32'd4);

        // Sustained stream of two-hit words, then a hitless eop word
        for (int k = 0; k < 8; k++)
            word(set_lane(set_lane(all_ff, 1, 8'h00), 14, 8'hF0), k == 0, 1'b0);
        word(all_ff, 1'b0, 1'b1);
        idle();
        repeat (30) tick();

        // Reset with hits pending; next word without sop starts at offset 0
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) word(set_lane(all_ff, 4, 8'h00), k == 0, 1'b0);
        idle();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        out_ready = 1'b1;
        tick();
        lb = dut_log.size();
        word(set_lane(all_ff, 2, 8'hFE), 1'b0, 1'b0);
        idle();
        wait_log(lb + 1);
        check_log("post_rst", lb, 16'd2, 8'h01, 1'b0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
